// File: rtl/eight_bit_serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives the request side, slave (the subtractor) drives the results.
interface eight_bit_serial_subtractor_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial 8-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Reports unsigned borrow-out and signed overflow; done pulses when results update.
module eight_bit_serial_subtractor (
  input  logic                         clk,
  input  logic                         rst,
  eight_bit_serial_subtractor_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e     state_q;
  logic [7:0] ar_q;
  logic [7:0] br_q;
  logic       c_q;
  logic [6:0] res_q;
  logic [2:0] cnt_q;
  logic       a7_q;
  logic       b7_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] diff_q;
  logic       bout_q;
  logic       ovf_q;

  logic d;
  logic c_next;

  // Full-subtractor on the current LSBs
  assign d      = ar_q[0] ^ br_q[0] ^ c_q;
  assign c_next = (~ar_q[0] & br_q[0]) | (~(ar_q[0] ^ br_q[0]) & c_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ar_q    <= 8'h00;
      br_q    <= 8'h00;
      c_q     <= 1'b0;
      res_q   <= 7'h00;
      cnt_q   <= 3'd0;
      a7_q    <= 1'b0;
      b7_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= 8'h00;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            ar_q    <= bus.a;
            br_q    <= bus.b;
            c_q     <= bus.bin;
            a7_q    <= bus.a[7];
            b7_q    <= bus.b[7];
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          ar_q  <= {1'b0, ar_q[7:1]};
          br_q  <= {1'b0, br_q[7:1]};
          c_q   <= c_next;
          res_q <= {d, res_q[6:1]};
          cnt_q <= cnt_q + 3'd1;
          // Eighth bit: publish the result, including the bit computed this cycle
          if (cnt_q == 3'd7) begin
            diff_q  <= {d, res_q};
            bout_q  <= c_next;
            ovf_q   <= (a7_q ^ b7_q) & (d ^ a7_q);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_eight_bit_serial_subtractor.sv
// Directed bench for the bit-serial subtractor: hand-computed vectors, handshake
// corner cases and asynchronous reset mid-operation.
module tb_eight_bit_serial_subtractor;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  eight_bit_serial_subtractor_if bus ();

  eight_bit_serial_subtractor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns at the negedge after the start edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.bin   = 1'b0;
  endtask

  // Called right after launch: checks busy/hold through the shift phase, then the results.
  // Returns at the negedge of the done cycle.
  task automatic finish_op(input string tag, input logic [7:0] prev_diff,
                           input logic [7:0] ediff, input logic ebout, input logic eovf);
    check1({tag, ".busy0"}, bus.busy, 1'b1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check1({tag, ".busy"}, bus.busy, 1'b1);
      check1({tag, ".done_early"}, bus.done, 1'b0);
      check8({tag, ".diff_hold"}, bus.diff, prev_diff);
    end
    @(negedge clk);
    check1({tag, ".done"}, bus.done, 1'b1);
    check1({tag, ".busy_end"}, bus.busy, 1'b0);
    check8({tag, ".diff"}, bus.diff, ediff);
    check1({tag, ".bout"}, bus.bout, ebout);
    check1({tag, ".ovf"}, bus.ovf, eovf);
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    check1({tag, ".done_clear"}, bus.done, 1'b0);
    check1({tag, ".busy_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.bin   = 1'b0;

    repeat (2) @(negedge clk);
    check1("rst.busy", bus.busy, 1'b0);
    check1("rst.done", bus.done, 1'b0);
    check8("rst.diff", bus.diff, 8'h00);
    check1("rst.bout", bus.bout, 1'b0);
    check1("rst.ovf", bus.ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    launch(8'h05, 8'h03, 1'b0);
    finish_op("basic", 8'h00, 8'h02, 1'b0, 1'b0);
    idle_after("basic");

    launch(8'h00, 8'h01, 1'b0);
    finish_op("uflow1", 8'h02, 8'hFF, 1'b1, 1'b0);
    idle_after("uflow1");

    launch(8'h00, 8'hFF, 1'b1);
    finish_op("uflow2", 8'hFF, 8'h00, 1'b1, 1'b0);
    idle_after("uflow2");

    launch(8'h80, 8'h01, 1'b0);
    finish_op("sovf1", 8'h00, 8'h7F, 1'b0, 1'b1);
    idle_after("sovf1");

    launch(8'h7F, 8'hFF, 1'b0);
    finish_op("sovf2", 8'h7F, 8'h80, 1'b1, 1'b1);
    idle_after("sovf2");

    launch(8'h10, 8'h0F, 1'b1);
    finish_op("chain", 8'h80, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("chain.hold_done", bus.done, 1'b0);
      check8("chain.hold_diff", bus.diff, 8'h00);
      check1("chain.hold_bout", bus.bout, 1'b0);
      check1("chain.hold_ovf", bus.ovf, 1'b0);
    end

    // Start during the 3rd shift cycle must be ignored
    launch(8'h05, 8'h03, 1'b0);
    @(negedge clk);
    @(negedge clk);
    launch(8'hAA, 8'h55, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check1("ign.busy", bus.busy, 1'b1);
      check1("ign.done_early", bus.done, 1'b0);
      @(negedge clk);
    end
    check1("ign.done", bus.done, 1'b1);
    check8("ign.diff", bus.diff, 8'h02);
    check1("ign.bout", bus.bout, 1'b0);
    check1("ign.ovf", bus.ovf, 1'b0);

    // Start in the done cycle is accepted back-to-back
    launch(8'h09, 8'h04, 1'b0);
    finish_op("b2b", 8'h02, 8'h05, 1'b0, 1'b0);
    idle_after("b2b");

    // Asynchronous reset in the 4th shift cycle
    launch(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    check1("mid.busy_pre", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("mid.busy", bus.busy, 1'b0);
    check1("mid.done", bus.done, 1'b0);
    check8("mid.diff", bus.diff, 8'h00);
    check1("mid.bout", bus.bout, 1'b0);
    check1("mid.ovf", bus.ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1("post.no_done", bus.done, 1'b0);
      check1("post.no_busy", bus.busy, 1'b0);
    end

    launch(8'h33, 8'h11, 1'b0);
    finish_op("after_rst", 8'h00, 8'h22, 1'b0, 1'b0);
    idle_after("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eight_bit_serial_subtractor.md
# eight_bit_serial_subtractor

Bit-serial 8-bit subtractor computing diff = a − b − bin, one bit per clock, LSB first. It is the arithmetic inverse of the team's 8-bit parallel adder and serves area-constrained datapaths where 8-cycle latency is acceptable. Operands are captured on a start handshake. The block reports unsigned borrow and signed overflow, and pulses done when the result registers update.

## Interface
- No parameters; width fixed at 8 bits.
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only while idle.
- a  input  8  minuend, captured with start.
- b  input  8  subtrahend, captured with start.
- bin  input  1  borrow-in, captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when results update.
- diff  output  8  result (a − b − bin) mod 256, registered.
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin.
- ovf  output  1  signed (two's complement) overflow of a − b − bin.

## Operation
- State machine states:
  - IDLE: busy=0. When start=1 at a rising edge, latch a, b and bin into internal shift registers and the borrow flop. Save a[7] and b[7]. Clear the bit counter to 0. Go to SHIFT.
  - SHIFT: busy=1. Each edge processes the LSBs ar0 and br0 with borrow c:
    - d = ar0 ^ br0 ^ c
    - c_next = (~ar0 & br0) | (~(ar0 ^ br0) & c)
    - d shifts into an internal result register from the MSB side; the operand registers shift right by one.
    - The counter increments.
    - On the edge where the counter equals 7 (the 8th bit):
      - diff ← completed result, including that bit
      - bout ← c_next
      - ovf ← (a7 ^ b7) & (d7 ^ a7), where d7 is the 8th bit and a7/b7 are the saved sign bits
      - done ← 1; state returns to IDLE.
- done is a registered output. It is cleared on the next edge.
- diff, bout and ovf hold their last values until the next completion. They do not change during SHIFT or on start.
- start while busy=1 is ignored. There is no queueing, and operand changes during SHIFT have no effect.
- start in the done cycle (state already IDLE) is accepted, so back-to-back operations are possible.
- Wrap-around: the result is always mod 256. The borrow is reported only via bout.

## Timing
- Reset (asynchronous assert): state=IDLE, busy=0, done=0, diff=0x00, bout=0, ovf=0, counter=0, internal registers=0.
- Reset mid-operation aborts immediately:
  - no done pulse
  - outputs return to reset values
  - first operation after deassertion requires a fresh start
- Latency for start sampled at edge k:
  - busy=1 after edges k through k+7.
  - Results, done=1 and busy=0 after edge k+8.
  - done=0 after edge k+9, unless a new operation completes then.
- Throughput: one operation per 9 cycles when start is held high continuously; the start in the done cycle is accepted at edge k+9.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Basic subtraction: reset, then start with a=0x05, b=0x03, bin=0.
  - busy high for 8 cycles; done pulses exactly 8 cycles after the start edge.
  - diff=0x02, bout=0, ovf=0.
- Unsigned underflow with wrap:
  - a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0.
  - a=0x00, b=0xFF, bin=1 → diff=0x00, bout=1, ovf=0.
- Signed overflow:
  - a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF, bin=0 → diff=0x80, bout=1, ovf=1.
- Borrow-in chaining: a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0, ovf=0. Results hold constant through 5 idle cycles afterwards.
- Handshake edge cases:
  - Pulse start with a=0xAA, b=0x55 in the 3rd SHIFT cycle of an op on 0x05−0x03 → ignored; result 0x02.
  - Start in the done cycle with a=0x09, b=0x04 → accepted; done 8 cycles later with diff=0x05.
- Reset mid-operation: assert rst asynchronously in the 4th SHIFT cycle.
  - All outputs go to 0 immediately, with no done pulse.
  - After release, a new start with a=0x33, b=0x11 → diff=0x22, bout=0, ovf=0.
